// File: rtl/alu_control_seq.sv
// alu_control_seq: ALU control decoder with a sequencer for multi-cycle MULT/DIV.
// Single-cycle operations decode combinationally with zero latency. MULT and DIV
// are accepted in IDLE and then walk through DATA_W iterations (the accept cycle
// plus DATA_W-1 BUSY cycles) while stalling the front end. A single DONE cycle
// follows, in which HI/LO are written.
module alu_control_seq #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  input  logic [2:0]                ALUop,
  input  logic [5:0]                function_code,
  input  logic                      abort,
  output logic [SEL_W-1:0]          select_bits_ALU,
  output logic                      stall,
  output logic                      step_en,
  output logic [$clog2(DATA_W)-1:0] iter_idx,
  output logic                      hilo_we,
  output logic                      illegal
);

  localparam int CNT_W = $clog2(DATA_W);

  // Index of the final iteration. The counter stops here, so it cannot wrap.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ALU select codes. They are zero-extended to SEL_W on the output.
  typedef enum logic [2:0] {
    SEL_ADD   = 3'd0,
    SEL_SUB   = 3'd1,
    SEL_AND   = 3'd2,
    SEL_OR    = 3'd3,
    SEL_SLT   = 3'd4,
    SEL_NOR   = 3'd5,
    SEL_MSTEP = 3'd6,
    SEL_DSTEP = 3'd7
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Main-decoder operation classes
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;

  // R-type funct field values
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sel_e             step_sel_q, step_sel_d;

  sel_e dec_sel;    // raw decode of ALUop/funct
  logic dec_legal;  // encoding is recognised
  logic dec_multi;  // encoding is MULT or DIV
  logic dec_ok;     // valid and legal instruction present
  sel_e idle_sel;   // select driven by the IDLE decode path
  sel_e sel_c;      // final select before zero-extension

  // Instruction decode, independent of sequencer state
  always_comb begin
    // NOTE: every variable gets a default before the case statements, so no
    // path leaves a value unassigned and no latch is inferred.
    dec_sel   = SEL_ADD;
    dec_legal = 1'b0;
    dec_multi = 1'b0;
    case (ALUop)
      OP_ADD: begin dec_sel = SEL_ADD; dec_legal = 1'b1; end
      OP_SUB: begin dec_sel = SEL_SUB; dec_legal = 1'b1; end
      OP_AND: begin dec_sel = SEL_AND; dec_legal = 1'b1; end
      OP_OR:  begin dec_sel = SEL_OR;  dec_legal = 1'b1; end
      OP_SLT: begin dec_sel = SEL_SLT; dec_legal = 1'b1; end
      OP_RTYPE: begin
        case (function_code)
          FN_ADD:  begin dec_sel = SEL_ADD; dec_legal = 1'b1; end
          FN_SUB:  begin dec_sel = SEL_SUB; dec_legal = 1'b1; end
          FN_AND:  begin dec_sel = SEL_AND; dec_legal = 1'b1; end
          FN_OR:   begin dec_sel = SEL_OR;  dec_legal = 1'b1; end
          FN_NOR:  begin dec_sel = SEL_NOR; dec_legal = 1'b1; end
          FN_SLT:  begin dec_sel = SEL_SLT; dec_legal = 1'b1; end
          FN_MULT: begin
            dec_sel   = SEL_MSTEP;
            dec_legal = 1'b1;
            dec_multi = 1'b1;
          end
          FN_DIV: begin
            dec_sel   = SEL_DSTEP;
            dec_legal = 1'b1;
            dec_multi = 1'b1;
          end
          default: begin
            dec_sel   = SEL_ADD;
            dec_legal = 1'b0;
          end
        endcase
      end
      default: begin
        dec_sel   = SEL_ADD;
        dec_legal = 1'b0;
      end
    endcase
  end

  // Invalid and undecodable instructions fall back to a harmless ADD
  assign dec_ok   = instr_valid & dec_legal;
  assign idle_sel = dec_ok ? dec_sel : SEL_ADD;

  // Sequencer next-state logic and outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_sel_d = step_sel_q;
    sel_c      = idle_sel;
    stall      = 1'b0;
    step_en    = 1'b0;
    iter_idx   = '0;
    hilo_we    = 1'b0;
    illegal    = instr_valid & ~dec_legal;

    case (state_q)
      ST_IDLE: begin
        if (dec_ok && dec_multi) begin
          // Accept cycle: this cycle already performs iteration 0
          sel_c      = dec_sel;
          stall      = 1'b1;
          step_en    = 1'b1;
          step_sel_d = dec_sel;
          if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_ONE;
          end
        end
      end

      ST_BUSY: begin
        // Front-end inputs are ignored while the operation iterates
        sel_c    = step_sel_q;
        stall    = 1'b1;
        step_en  = 1'b1;
        iter_idx = cnt_q;
        illegal  = 1'b0;
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        // Retire cycle. An abort here drops the HI/LO write.
        // No new instruction is accepted in this cycle.
        sel_c   = step_sel_q;
        hilo_we = ~abort;
        illegal = 1'b0;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // While reset is asserted, only the plain IDLE decode is visible
    if (reset) begin
      sel_c    = idle_sel;
      illegal  = instr_valid & ~dec_legal;
      stall    = 1'b0;
      step_en  = 1'b0;
      iter_idx = '0;
      hilo_we  = 1'b0;
    end
  end

  assign select_bits_ALU = SEL_W'(sel_c);

  // State, iteration counter and latched step code. Reset wins over abort.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the clock edge.
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      step_sel_q <= SEL_ADD;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_sel_q <= step_sel_d;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq. One instance uses DATA_W=32 and a
// second uses DATA_W=8. Both instances share the stimulus. Each check names
// the instance it targets.
module tb_alu_control_seq;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_R = 3'b010,
                         OP_AND = 3'b011, OP_OR = 3'b100, OP_SLT = 3'b101;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_NOR = 6'b100111, F_SLT = 6'b101010,
                         F_MULT = 6'b011000, F_DIV = 6'b011010, F_BAD = 6'b000111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, instr_valid, abort;
  logic [2:0] alu_op;
  logic [5:0] funct;

  logic [3:0] sel32, sel8;
  logic       stall32, step32, hilo32, ill32;
  logic       stall8, step8, hilo8, ill8;
  logic [4:0] iter32;
  logic [2:0] iter8;

  alu_control_seq #(.DATA_W(32), .SEL_W(4)) dut32 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .ALUop(alu_op),
    .function_code(funct), .abort(abort), .select_bits_ALU(sel32),
    .stall(stall32), .step_en(step32), .iter_idx(iter32), .hilo_we(hilo32),
    .illegal(ill32)
  );

  alu_control_seq #(.DATA_W(8), .SEL_W(4)) dut8 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .ALUop(alu_op),
    .function_code(funct), .abort(abort), .select_bits_ALU(sel8),
    .stall(stall8), .step_en(step8), .iter_idx(iter8), .hilo_we(hilo8),
    .illegal(ill8)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic       stall;
    logic       step_en;
    logic [5:0] iter;
    logic       hilo_we;
    logic       illegal;
  } exp_t;

  typedef struct {
    string name;
    int    which;  // 0 = dut32, 1 = dut8
    exp_t  e;
  } sb_t;

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [5:0] fn;
    logic       ab;
    logic [3:0] sel;
    logic       ill;
  } vec_t;

  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t zero_e;

  function automatic exp_t mk(input int sel, input logic st, input logic se,
                              input int it, input logic hw, input logic il);
    exp_t e;
    e.sel     = 4'(sel);
    e.stall   = st;
    e.step_en = se;
    e.iter    = 6'(it);
    e.hilo_we = hw;
    e.illegal = il;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic ab, input logic rs);
    instr_valid = v;
    alu_op      = op;
    funct       = fn;
    abort       = ab;
    reset       = rs;
  endtask

  task automatic push(input string name, input int which, input exp_t e);
    sb_t r;
    r.name  = name;
    r.which = which;
    r.e     = e;
    sb_q.push_back(r);
  endtask

  // Compare every queued expectation at the falling edge, then advance one cycle
  task automatic tick();
    sb_t  r;
    exp_t act;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      if (r.which == 0)
        act = {sel32, stall32, step32, {1'b0, iter32}, hilo32, ill32};
      else
        act = {sel8, stall8, step8, {3'b000, iter8}, hilo8, ill8};
      n_cmp++;
      if (act !== r.e) begin
        n_bad++;
        $display("FAIL %s (dut%0d) t=%0t: got sel=%0d stall=%b step=%b iter=%0d hilo=%b ill=%b, want sel=%0d stall=%b step=%b iter=%0d hilo=%b ill=%b",
                 r.name, (r.which == 0) ? 32 : 8, $time,
                 act.sel, act.stall, act.step_en, act.iter, act.hilo_we, act.illegal,
                 r.e.sel, r.e.stall, r.e.step_en, r.e.iter, r.e.hilo_we, r.e.illegal);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b1);
    push("reset_in32", 0, zero_e);
    push("reset_in8", 1, zero_e);
    tick();
    drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
    push("reset_after32", 0, zero_e);
    push("reset_after8", 1, zero_e);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[16];
    zero_e = mk(0, 0, 0, 0, 0, 0);

    vecs[0]  = '{1'b1, OP_ADD, 6'd0,  1'b0, 4'd0, 1'b0};
    vecs[1]  = '{1'b1, OP_SUB, 6'd0,  1'b0, 4'd1, 1'b0};
    vecs[2]  = '{1'b1, OP_AND, 6'd0,  1'b0, 4'd2, 1'b0};
    vecs[3]  = '{1'b1, OP_OR,  6'd0,  1'b0, 4'd3, 1'b0};
    vecs[4]  = '{1'b1, OP_SLT, 6'd0,  1'b0, 4'd4, 1'b0};
    vecs[5]  = '{1'b1, 3'b110, 6'd0,  1'b0, 4'd0, 1'b1};
    vecs[6]  = '{1'b1, 3'b111, 6'd0,  1'b0, 4'd0, 1'b1};
    vecs[7]  = '{1'b1, OP_R,   F_ADD, 1'b0, 4'd0, 1'b0};
    vecs[8]  = '{1'b1, OP_R,   F_SUB, 1'b0, 4'd1, 1'b0};
    vecs[9]  = '{1'b1, OP_R,   F_AND, 1'b0, 4'd2, 1'b0};
    vecs[10] = '{1'b1, OP_R,   F_OR,  1'b0, 4'd3, 1'b0};
    vecs[11] = '{1'b1, OP_R,   F_NOR, 1'b0, 4'd5, 1'b0};
    vecs[12] = '{1'b1, OP_R,   F_SLT, 1'b0, 4'd4, 1'b0};
    vecs[13] = '{1'b1, OP_R,   F_BAD, 1'b0, 4'd0, 1'b1};
    vecs[14] = '{1'b0, OP_R,   F_BAD, 1'b0, 4'd0, 1'b0};
    vecs[15] = '{1'b1, OP_SUB, 6'd0,  1'b1, 4'd1, 1'b0};  // abort in IDLE is harmless

    drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    do_reset();

    // Single-cycle decode: zero latency, never stalls
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].fn, vecs[i].ab, 1'b0);
      push($sformatf("vec%0d", i), 0, mk(vecs[i].sel, 0, 0, 0, 0, vecs[i].ill));
      push($sformatf("vec%0d", i), 1, mk(vecs[i].sel, 0, 0, 0, 0, vecs[i].ill));
      tick();
    end

    // DATA_W=32 MULT: 32 stall cycles, hilo_we at cycle 32, IDLE at cycle 33
    do_reset();
    drive(1'b1, OP_R, F_MULT, 1'b0, 1'b0);
    push("mult32_accept", 0, mk(6, 1, 1, 0, 0, 0));
    tick();
    for (int k = 1; k < 32; k++) begin
      drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
      push($sformatf("mult32_busy%0d", k), 0, mk(6, 1, 1, k, 0, 0));
      tick();
    end
    push("mult32_done", 0, mk(6, 0, 0, 0, 1, 0));
    tick();
    push("mult32_idle", 0, zero_e);
    tick();

    // DATA_W=8 DIV with ADD and illegal inputs during BUSY, MULT offered in DONE
    do_reset();
    drive(1'b1, OP_R, F_DIV, 1'b0, 1'b0);
    push("div8_accept", 1, mk(7, 1, 1, 0, 0, 0));
    tick();
    for (int k = 1; k < 8; k++) begin
      if (k == 3) drive(1'b1, 3'b111, 6'd0, 1'b0, 1'b0);
      else        drive(1'b1, OP_ADD, 6'd0, 1'b0, 1'b0);
      push($sformatf("div8_busy%0d", k), 1, mk(7, 1, 1, k, 0, 0));
      tick();
    end
    drive(1'b1, OP_R, F_MULT, 1'b0, 1'b0);
    push("div8_done", 1, mk(7, 0, 0, 0, 1, 0));
    tick();
    drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
    push("div8_no_accept_in_done", 1, zero_e);
    tick();

    // DATA_W=8 MULT aborted at cycle 5: IDLE at cycle 6, hilo_we never asserted
    do_reset();
    drive(1'b1, OP_R, F_MULT, 1'b0, 1'b0);
    push("abort_accept", 1, mk(6, 1, 1, 0, 0, 0));
    tick();
    for (int k = 1; k < 5; k++) begin
      drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
      push($sformatf("abort_busy%0d", k), 1, mk(6, 1, 1, k, 0, 0));
      tick();
    end
    drive(1'b0, OP_ADD, 6'd0, 1'b1, 1'b0);
    push("abort_cycle5", 1, mk(6, 1, 1, 5, 0, 0));
    tick();
    for (int k = 6; k < 12; k++) begin
      drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
      push($sformatf("abort_after%0d", k), 1, zero_e);
      tick();
    end

    // Abort in the accept cycle: back to IDLE immediately
    do_reset();
    drive(1'b1, OP_R, F_MULT, 1'b1, 1'b0);
    push("abort_at_accept", 1, mk(6, 1, 1, 0, 0, 0));
    tick();
    drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
    push("abort_at_accept_next", 1, zero_e);
    tick();

    // Abort in DONE suppresses the HI/LO write
    do_reset();
    drive(1'b1, OP_R, F_MULT, 1'b0, 1'b0);
    push("done_abort_accept", 1, mk(6, 1, 1, 0, 0, 0));
    tick();
    for (int k = 1; k < 8; k++) begin
      drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
      push($sformatf("done_abort_busy%0d", k), 1, mk(6, 1, 1, k, 0, 0));
      tick();
    end
    drive(1'b0, OP_ADD, 6'd0, 1'b1, 1'b0);
    push("done_abort_done", 1, mk(6, 0, 0, 0, 0, 0));
    tick();
    drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
    push("done_abort_idle", 1, zero_e);
    tick();

    // DATA_W=32 MULT with reset at cycle 10, then a new MULT at cycle 12
    do_reset();
    drive(1'b1, OP_R, F_MULT, 1'b0, 1'b0);
    push("rst_accept", 0, mk(6, 1, 1, 0, 0, 0));
    tick();
    for (int k = 1; k < 10; k++) begin
      drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
      push($sformatf("rst_busy%0d", k), 0, mk(6, 1, 1, k, 0, 0));
      tick();
    end
    drive(1'b0, OP_ADD, 6'd0, 1'b1, 1'b1);  // reset outranks abort
    push("rst_cycle10", 0, zero_e);
    tick();
    drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
    push("rst_cycle11", 0, zero_e);
    tick();
    drive(1'b1, OP_R, F_MULT, 1'b0, 1'b0);
    push("rst_new_accept", 0, mk(6, 1, 1, 0, 0, 0));
    tick();
    for (int k = 1; k < 32; k++) begin
      drive(1'b0, OP_ADD, 6'd0, 1'b0, 1'b0);
      push($sformatf("rst_new_busy%0d", k), 0, mk(6, 1, 1, k, 0, 0));
      tick();
    end
    push("rst_new_done", 0, mk(6, 0, 0, 0, 1, 0));
    tick();
    push("rst_new_idle", 0, zero_e);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
